pc_src_ctrl: RTL
================

// Module: pc_src_ctrl
// PURPOSE
//  Sequencer that drives the select of the 7-input PC source mux (mux6) and the PC/EPC write
//  strobes. Takes a decoded PC-update request or an exception flag from the main control and
//  emits the cycle-exact pc_mux_sel/pc_write sequence, including the exception path: EPC save,
//  vector fetch from memory, PC load from Mem. Sits between the control unit and mux6/PC/EPC.
// PARAMETERS
//  WAIT_CYCLES  1        memory read latency in cycles, 1..15; exception path waits this long
//  VEC_BASE     32'd253  vector byte address for opcode exc; overflow +1, div-by-zero +2
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  start          in   1   1-cycle request: perform PC update of class pc_op
//  pc_op          in   3   000 SEQ, 001 BRANCH, 010 JUMP, 011 JR, 100 RTE, 101 LDPC, 11x illegal
//  branch_taken   in   1   branch condition, sampled with start
//  exc_opcode     in   1   invalid-opcode exception pulse
//  exc_ovf        in   1   ALU overflow exception pulse
//  exc_div        in   1   divide-by-zero exception pulse
//  pc_mux_sel     out  3   mux6 select: 000 A,001 ULAout,010 SLAC,011 EPCout,100 MDRout,101 ulaResult,110 Mem
//  pc_write       out  1   PC load strobe
//  epc_write      out  1   EPC load strobe
//  mem_read       out  1   memory read request for vector fetch
//  exc_addr       out  32  vector byte address, valid while mem_read=1
//  exc_cause      out  2   00 none, 01 opcode, 10 overflow, 11 div; held until next exception
//  busy           out  1   1 in any state other than IDLE
//  done           out  1   1-cycle pulse on final cycle of every sequence
// BEHAVIOUR
//  All outputs registered (Moore). Reset (reset_n=0, async): state IDLE, pc_mux_sel=101,
//   pc_write=epc_write=mem_read=busy=done=0, exc_addr=0, exc_cause=00, wait counter=0.
//  States: IDLE, UPDATE, EXC_SAVE, EXC_ADDR, EXC_WAIT, EXC_LOAD.
//  IDLE: requests accepted only here; start/exc while busy are ignored (not queued).
//  Normal path: start at cycle N, no exception -> UPDATE at N+1: pc_mux_sel per pc_op
//   (SEQ 101, BRANCH 001, JUMP 010, JR 000, RTE 011, LDPC 100), pc_write=1, done=1, busy=1;
//   N+2 back to IDLE. BRANCH with branch_taken=0: pc_write=0 in UPDATE, done still 1.
//  pc_op=11x with start: treated exactly as exc_opcode raised that cycle.
//  Exception priority when several flags same cycle: opcode > overflow > div.
//   Exception in same cycle as start: exception wins, start dropped.
//  Exception path, flag at cycle N: exc_cause updated at N+1.
//   N+1 EXC_SAVE: epc_write=1.
//   N+2 EXC_ADDR: mem_read=1, exc_addr=VEC_BASE+{0,1,2}; counter loaded WAIT_CYCLES.
//   EXC_WAIT for WAIT_CYCLES cycles: mem_read=1, exc_addr held, counter decrements to 0.
//   then EXC_LOAD: mem_read=0, pc_mux_sel=110, pc_write=1, done=1; next cycle IDLE.
//   WAIT_CYCLES=1 -> pc_write at N+4, total 5 cycles incl. return to IDLE.
//  Outside UPDATE/EXC_LOAD pc_mux_sel rests at 101; exc_addr returns to 0 outside ADDR/WAIT.
//  Exception flags during exception sequence: ignored (no nesting).
//  reset_n low mid-sequence: immediate return to reset values; no partial PC/EPC write follows.
// TESTING
//  Reset: reset_n=0 -> pc_mux_sel=101, all strobes 0, busy 0; async clear mid-UPDATE verified.
//  start, pc_op=010 at N -> N+1 pc_mux_sel=010, pc_write=1, done=1; N+2 busy=0.
//  BRANCH: branch_taken=1 -> sel 001, pc_write=1; branch_taken=0 -> pc_write=0, done=1.
//  exc_ovf at N, WAIT_CYCLES=1 -> N+1 epc_write; N+2,N+3 mem_read=1, exc_addr=254;
//   N+4 sel=110, pc_write=1, done=1; exc_cause=10.
//  exc_ovf+exc_div+start same cycle -> overflow sequence, exc_addr=254, no UPDATE state.
//  start pc_op=111 -> opcode sequence, exc_addr=253, exc_cause=01; start during busy ignored.

Source files
------------

// File: rtl/pc_src_ctrl.sv
// ---------------------------------------------------------------------------
// pc_src_ctrl
// Sequences the PC source mux select (mux6) and the PC/EPC write strobes for
// one PC update or one exception entry at a time. Exception entry saves EPC,
// fetches the handler vector from memory and loads PC from the memory data.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         1-cycle request to perform a PC update of class pc_op
//   pc_op[2:0]    000 SEQ, 001 BRANCH, 010 JUMP, 011 JR, 100 RTE, 101 LDPC,
//                 11x illegal (raises an opcode exception)
//   branch_taken  branch condition, sampled with start
//   exc_opcode    invalid-opcode exception pulse
//   exc_ovf       ALU overflow exception pulse
//   exc_div       divide-by-zero exception pulse
//   pc_mux_sel    mux6 select (000 A .. 110 Mem), rests at 101 (ulaResult)
//   pc_write      PC load strobe
//   epc_write     EPC load strobe
//   mem_read      vector fetch read request
//   exc_addr      vector byte address, valid while mem_read=1
//   exc_cause     00 none, 01 opcode, 10 overflow, 11 div-by-zero (sticky)
//   busy          high whenever the sequencer is not idle
//   done          1-cycle pulse on the final cycle of every sequence
// ---------------------------------------------------------------------------
module pc_src_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] VEC_BASE    = 32'd253
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  pc_op,
    input  logic        branch_taken,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div,
    output logic [2:0]  pc_mux_sel,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_read,
    output logic [31:0] exc_addr,
    output logic [1:0]  exc_cause,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = 4;

    // mux6 select encodings
    localparam logic [2:0] SEL_A       = 3'b000;
    localparam logic [2:0] SEL_ULAOUT  = 3'b001;
    localparam logic [2:0] SEL_SLAC    = 3'b010;
    localparam logic [2:0] SEL_EPCOUT  = 3'b011;
    localparam logic [2:0] SEL_MDROUT  = 3'b100;
    localparam logic [2:0] SEL_ULARES  = 3'b101;
    localparam logic [2:0] SEL_MEM     = 3'b110;

    // PC-update classes
    localparam logic [2:0] OP_SEQ      = 3'b000;
    localparam logic [2:0] OP_BRANCH   = 3'b001;
    localparam logic [2:0] OP_JUMP     = 3'b010;
    localparam logic [2:0] OP_JR       = 3'b011;
    localparam logic [2:0] OP_RTE      = 3'b100;
    localparam logic [2:0] OP_LDPC     = 3'b101;

    // exception causes
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_OPC   = 2'b01;
    localparam logic [1:0] CAUSE_OVF   = 2'b10;
    localparam logic [1:0] CAUSE_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UPDATE   = 3'd1,
        ST_EXC_SAVE = 3'd2,
        ST_EXC_ADDR = 3'd3,
        ST_EXC_WAIT = 3'd4,
        ST_EXC_LOAD = 3'd5
    } state_e;

    state_e             state_q;
    logic [2:0]         pc_mux_sel_q;
    logic               pc_write_q;
    logic               epc_write_q;
    logic               mem_read_q;
    logic [31:0]        exc_addr_q;
    logic [1:0]         exc_cause_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   wait_cnt_q;

    logic               illegal_op_c;
    logic               exc_req_c;
    logic [1:0]         cause_c;
    logic [2:0]         upd_sel_c;
    logic               upd_write_c;
    logic [31:0]        vec_addr_c;

    // Request decode: an illegal pc_op with start counts as an opcode exception
    always_comb begin
        illegal_op_c = start && (pc_op[2:1] == 2'b11);
        exc_req_c    = exc_opcode || illegal_op_c || exc_ovf || exc_div;

        cause_c = CAUSE_DIV;
        if (exc_opcode || illegal_op_c) begin
            cause_c = CAUSE_OPC;
        end else if (exc_ovf) begin
            cause_c = CAUSE_OVF;
        end
    end

    // PC source for a normal update
    always_comb begin
        upd_sel_c = SEL_ULARES;
        case (pc_op)
            OP_SEQ:    upd_sel_c = SEL_ULARES;
            OP_BRANCH: upd_sel_c = SEL_ULAOUT;
            OP_JUMP:   upd_sel_c = SEL_SLAC;
            OP_JR:     upd_sel_c = SEL_A;
            OP_RTE:    upd_sel_c = SEL_EPCOUT;
            OP_LDPC:   upd_sel_c = SEL_MDROUT;
            default:   upd_sel_c = SEL_ULARES;
        endcase
        // Untaken branch still completes the sequence, just without a PC load
        upd_write_c = (pc_op != OP_BRANCH) || branch_taken;
    end

    // Vector address from the latched cause: opcode +0, overflow +1, div +2
    always_comb begin
        vec_addr_c = VEC_BASE;
        case (exc_cause_q)
            CAUSE_OVF: vec_addr_c = VEC_BASE + 32'd1;
            CAUSE_DIV: vec_addr_c = VEC_BASE + 32'd2;
            default:   vec_addr_c = VEC_BASE;
        endcase
    end

    // Sequencer: state and all outputs registered together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_mux_sel_q <= SEL_ULARES;
            pc_write_q   <= 1'b0;
            epc_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            exc_addr_q   <= '0;
            exc_cause_q  <= CAUSE_NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them
            pc_mux_sel_q <= SEL_ULARES;
            pc_write_q   <= 1'b0;
            epc_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            exc_addr_q   <= '0;
            done_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (exc_req_c) begin
                        // Exception wins over a simultaneous start
                        state_q     <= ST_EXC_SAVE;
                        exc_cause_q <= cause_c;
                        epc_write_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (start) begin
                        state_q      <= ST_UPDATE;
                        pc_mux_sel_q <= upd_sel_c;
                        pc_write_q   <= upd_write_c;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                ST_EXC_SAVE: begin
                    state_q    <= ST_EXC_ADDR;
                    mem_read_q <= 1'b1;
                    exc_addr_q <= vec_addr_c;
                    wait_cnt_q <= CNT_W'(WAIT_CYCLES);
                    busy_q     <= 1'b1;
                end

                ST_EXC_ADDR: begin
                    state_q    <= ST_EXC_WAIT;
                    mem_read_q <= 1'b1;
                    exc_addr_q <= exc_addr_q;
                    busy_q     <= 1'b1;
                end

                ST_EXC_WAIT: begin
                    busy_q <= 1'b1;
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                    // Leave on the last wait cycle; counter lands on zero
                    if (wait_cnt_q <= CNT_W'(1)) begin
                        state_q      <= ST_EXC_LOAD;
                        pc_mux_sel_q <= SEL_MEM;
                        pc_write_q   <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        mem_read_q <= 1'b1;
                        exc_addr_q <= exc_addr_q;
                    end
                end

                ST_EXC_LOAD: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_mux_sel = pc_mux_sel_q;
    assign pc_write   = pc_write_q;
    assign epc_write  = epc_write_q;
    assign mem_read   = mem_read_q;
    assign exc_addr   = exc_addr_q;
    assign exc_cause  = exc_cause_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
